// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier.
// Performs one Booth recoding step per clock. A product is ready WIDTH+1
// cycles after the operation is accepted. Operations can be signed or
// unsigned, chosen separately for each operation.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      requests an operation (accepted in IDLE or DONE)
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   x, y       multiplicand / multiplier, sampled on the accepting edge
//   salida     registered 2*WIDTH-bit product, held until the next result
//   busy       high while iterating
//   done       one-cycle pulse after salida is updated
module booth_seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   salida,
    output logic                 busy,
    output logic                 done
);

    // Counter holds 0..WIDTH.
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH+1:0] a_r;
    logic [WIDTH+1:0] a_nxt_s;
    logic [WIDTH+1:0] sum_s;
    logic [WIDTH+1:0] m_ext_s;
    logic [WIDTH:0]   m_r;
    logic [WIDTH:0]   q_r;
    logic [WIDTH:0]   q_nxt_s;
    logic             q_m1_r;
    logic [CW-1:0]    cnt_r;
    logic             load_s;
    logic             last_s;

    // One Booth step: conditional add/subtract, then arithmetic shift of {A,Q,Q-1}.
    always_comb begin
        m_ext_s = {m_r[WIDTH], m_r};
        case ({q_r[0], q_m1_r})
            2'b01:   sum_s = a_r + m_ext_s;
            2'b10:   sum_s = a_r - m_ext_s;
            default: sum_s = a_r;
        endcase
        a_nxt_s = {sum_s[WIDTH+1], sum_s[WIDTH+1:1]};
        q_nxt_s = {sum_s[0], q_r[WIDTH:1]};
    end

    // Acceptance and last-step qualifiers.
    always_comb begin
        load_s = start && ((state_r == IDLE) || (state_r == DONE));
        last_s = (state_r == RUN) && (cnt_r == CW'(WIDTH));
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus registered busy/done, both derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s == RUN);
            done    <= (state_nxt_s == DONE);
        end
    end

    // Datapath: load extended operands on accept, iterate in RUN, capture the product on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            q_r    <= '0;
            m_r    <= '0;
            q_m1_r <= 1'b0;
            cnt_r  <= '0;
            salida <= '0;
        end else if (load_s) begin
            // The extra operand bit makes unsigned values positive in two's complement.
            m_r    <= is_signed ? {x[WIDTH-1], x} : {1'b0, x};
            q_r    <= is_signed ? {y[WIDTH-1], y} : {1'b0, y};
            a_r    <= '0;
            q_m1_r <= 1'b0;
            cnt_r  <= '0;
        end else if (state_r == RUN) begin
            a_r    <= a_nxt_s;
            q_r    <= q_nxt_s;
            q_m1_r <= q_r[0];
            cnt_r  <= cnt_r + CW'(1);
            if (last_s) begin
                // The exact product always fits in the low 2*WIDTH bits of {A,Q}.
                salida <= {a_nxt_s[WIDTH-2:0], q_nxt_s};
            end else begin
                salida <= salida;
            end
        end else begin
            a_r    <= a_r;
            q_r    <= q_r;
            m_r    <= m_r;
            q_m1_r <= q_m1_r;
            cnt_r  <= cnt_r;
            salida <= salida;
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult. It drives a WIDTH=4 instance and
// a WIDTH=8 instance and checks their products against plain integer
// multiplication.
module tb_booth_seq_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       s4, sg4, b4, d4;
    logic [3:0] x4, y4;
    logic [7:0] p4;
    logic       s8, sg8, b8, d8;
    logic [7:0] x8, y8;
    logic [15:0] p8;

    booth_seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .is_signed(sg4),
        .x(x4), .y(y4), .salida(p4), .busy(b4), .done(d4)
    );
    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .is_signed(sg8),
        .x(x8), .y(y8), .salida(p8), .busy(b8), .done(d8)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          w;
        bit          sg;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] e;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Reference: extend the operands to integers and multiply.
    function automatic logic [15:0] ref_prod(input int w, input bit sg,
                                             input logic [7:0] a, input logic [7:0] b);
        longint av, bv, mask, p;
        mask = (64'sd1 <<< w) - 64'sd1;
        av = longint'(a) & mask;
        bv = longint'(b) & mask;
        if (sg && a[w-1]) av = av - (64'sd1 <<< w);
        if (sg && b[w-1]) bv = bv - (64'sd1 <<< w);
        p = (av * bv) & ((64'sd1 <<< (2*w)) - 64'sd1);
        return 16'(p);
    endfunction

    // Runs one operation and returns the result, the latency and the number of busy cycles.
    task automatic op(input int w, input bit sg, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] res, output int lat, output int busy_n);
        @(negedge clk);
        if (w == 4) begin
            s4 = 1'b1; sg4 = sg; x4 = a[3:0]; y4 = b[3:0];
        end else begin
            s8 = 1'b1; sg8 = sg; x8 = a; y8 = b;
        end
        @(posedge clk); #1;
        s4 = 1'b0; s8 = 1'b0;
        lat = 0; busy_n = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if ((w == 4) ? b4 : b8) busy_n++;
            @(posedge clk); #1;
            if ((w == 4) ? d4 : d8) lat = k;
        end
        res = (w == 4) ? {8'h00, p4} : p8;
        if (lat == 0) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk); #1;
            chk("done_fall", 64'((w == 4) ? d4 : d8), 64'd0);
        end
    endtask

    logic [15:0] res;
    int lat, busy_n, cnt, ndone;
    logic [7:0] ra, rb;
    logic [3:0] bbx[4];
    logic [3:0] bby[4];
    bit         bbs[4];

    initial begin
        tbl[0] = '{4, 1'b1, 8'h0A, 8'h02, 16'h00F4};
        tbl[1] = '{4, 1'b0, 8'h0A, 8'h02, 16'h0014};
        tbl[2] = '{4, 1'b0, 8'h0F, 8'h0F, 16'h00E1};
        tbl[3] = '{4, 1'b1, 8'h08, 8'h08, 16'h0040};
        tbl[4] = '{4, 1'b1, 8'h07, 8'h08, 16'h00C8};
        tbl[5] = '{8, 1'b1, 8'h80, 8'h80, 16'h4000};
        tbl[6] = '{8, 1'b0, 8'hFF, 8'hFF, 16'hFE01};

        rst = 1'b1; s4 = 1'b0; sg4 = 1'b0; x4 = 4'h0; y4 = 4'h0;
        s8 = 1'b0; sg8 = 1'b0; x8 = 8'h00; y8 = 8'h00;
        #1;
        chk("rst_salida4", 64'(p4), 64'd0);
        chk("rst_busy4", 64'(b4), 64'd0);
        chk("rst_done4", 64'(d4), 64'd0);
        chk("rst_salida8", 64'(p8), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            op(tbl[i].w, tbl[i].sg, tbl[i].a, tbl[i].b, res, lat, busy_n);
            chk("vec_prod", 64'(res), 64'(tbl[i].e));
            chk("vec_lat", 64'(lat), 64'(tbl[i].w + 1));
            chk("vec_busy", 64'(busy_n), 64'(tbl[i].w + 1));
        end

        // A start pulse in the middle of RUN is ignored: 3 * -2 = -6.
        @(negedge clk);
        s4 = 1'b1; sg4 = 1'b1; x4 = 4'h3; y4 = 4'hE;
        @(posedge clk); #1; s4 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); s4 = 1'b1; sg4 = 1'b0; x4 = 4'h7; y4 = 4'h7;
        @(posedge clk); #1; s4 = 1'b0;
        cnt = 2;
        while (!d4 && cnt < 20) begin
            @(posedge clk); #1; cnt++;
        end
        chk("midstart_lat", 64'(cnt), 64'd5);
        chk("midstart_prod", 64'(p4), 64'h00FA);
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (d4) ndone++;
        end
        chk("midstart_extra_done", 64'(ndone), 64'd0);

        // With start held high, a result comes out every WIDTH+2 cycles.
        bbx = '{4'h5, 4'hF, 4'h8, 4'h3};
        bby = '{4'h3, 4'hF, 4'h7, 4'hD};
        bbs = '{1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        s4 = 1'b1; sg4 = bbs[0]; x4 = bbx[0]; y4 = bby[0];
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            do begin
                @(posedge clk); #1; cnt++;
            end while (!d4 && cnt < 20);
            chk("b2b_gap", 64'(cnt), (k == 0) ? 64'd5 : 64'd6);
            chk("b2b_prod", 64'(p4), 64'(ref_prod(4, bbs[k], {4'h0, bbx[k]}, {4'h0, bby[k]})));
            if (k < 3) begin
                sg4 = bbs[k+1]; x4 = bbx[k+1]; y4 = bby[k+1];
            end else begin
                s4 = 1'b0;
            end
        end
        repeat (8) @(posedge clk);

        // An asynchronous reset during RUN aborts the operation.
        @(negedge clk);
        s4 = 1'b1; sg4 = 1'b0; x4 = 4'h5; y4 = 4'h3;
        @(posedge clk); #1; s4 = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(b4), 64'd0);
        chk("midrst_done", 64'(d4), 64'd0);
        chk("midrst_salida", 64'(p4), 64'd0);
        #1 rst = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (d4) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);
        op(4, 1'b0, 8'h09, 8'h09, res, lat, busy_n);
        chk("postrst_prod", 64'(res), 64'h0051);

        // Random operand pairs, both modes, against the reference model.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            for (int m = 0; m < 2; m++) begin
                op(8, m[0], ra, rb, res, lat, busy_n);
                chk("rand8_prod", 64'(res), 64'(ref_prod(8, m[0], ra, rb)));
                chk("rand8_lat", 64'(lat), 64'd9);
            end
        end
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom_range(0, 15));
            rb = 8'($urandom_range(0, 15));
            op(4, i[0], ra, rb, res, lat, busy_n);
            chk("rand4_prod", 64'(res), 64'(ref_prod(4, i[0], ra, rb)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
